multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 56 +++++
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/multicycle_ctrl_outdec.sv | 70 +++++++
 rtl/multicycle_ctrl.sv | 110 +++++++++++
 tb/tb_multicycle_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared types and codes for the multicycle controller
// Holds opcodes, state encodings, datapath select codes and the strobe bundle.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ_EX   = 4'd8,
    S_J_EX     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - controller <-> datapath signal bundle
// master = controller, slave = datapath side.
interface multicycle_ctrl_if;
  logic [5:0] Op;
  logic       Zero;
  logic       MemReady;
  logic       MemRead;
  logic       MemWrite;
  logic       IorD;
  logic       IRWrite;
  logic       PCEn;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic [3:0] State;
  logic       IllegalOp;
  logic       Fault;

  modport master (
    input  Op, Zero, MemReady,
    output MemRead, MemWrite, IorD, IRWrite, PCEn, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, State, IllegalOp, Fault
  );

  modport slave (
    output Op, Zero, MemReady,
    input  MemRead, MemWrite, IorD, IRWrite, PCEn, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, State, IllegalOp, Fault
  );
endinterface

// File: rtl/multicycle_ctrl_outdec.sv
// rtl/multicycle_ctrl_outdec.sv - combinational state-to-strobe decode
// Reset forces every strobe low without waiting for a clock edge.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  input  logic   i_zero,
  input  logic   i_rst,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_4;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_en     = i_mem_ready;
      end
      S_DECODE:   o_ctrl.alu_src_b = SRCB_IMMSH;
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = 1'b1;
      end
      S_RTYPE_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      S_BEQ_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALUOP_SUB;
        o_ctrl.pc_source = PCSRC_ALUOUT;
        o_ctrl.pc_en     = i_zero;
      end
      S_J_EX: begin
        o_ctrl.pc_source = PCSRC_JUMP;
        o_ctrl.pc_en     = 1'b1;
      end
      S_ADDI_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB:  o_ctrl.reg_write = 1'b1;
      default:    o_ctrl = '0;
    endcase
    if (i_rst) o_ctrl = '0;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS-style control FSM with memory-wait watchdog
// Optional addi support enabled by defining MULTICYCLE_CTRL_ADDI_EN.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic               Clock,
  input  logic               Reset,
  multicycle_ctrl_if.master  bus
);

  localparam int WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_WAIT_MAX);

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait;
  logic              r_fault;

  state_t            w_next;
  logic [WAIT_W-1:0] w_wait_next;
  logic              w_illegal;
  logic              w_mem_state;
  ctrl_t             w_ctrl;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_next;
      if (w_next == S_HALT) r_fault <= 1'b1;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_illegal   = 1'b0;
    w_wait_next = '0;
    w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    case (r_state)
      S_FETCH:  if (bus.MemReady) w_next = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_RTYPE:     w_next = S_RTYPE_EX;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BEQ_EX;
          OP_J:         w_next = S_J_EX;
`ifdef MULTICYCLE_CTRL_ADDI_EN
          OP_ADDI:      w_next = S_ADDI_EX;
`endif
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR:   w_next = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    if (bus.MemReady) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWR:    if (bus.MemReady) w_next = S_FETCH;
      S_RTYPE_EX: w_next = S_RTYPE_WB;
      S_RTYPE_WB: w_next = S_FETCH;
      S_BEQ_EX:   w_next = S_FETCH;
      S_J_EX:     w_next = S_FETCH;
`ifdef MULTICYCLE_CTRL_ADDI_EN
      S_ADDI_EX:  w_next = S_ADDI_WB;
      S_ADDI_WB:  w_next = S_FETCH;
`endif
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_FETCH;
    endcase
    // A ready on the limit cycle still completes; only a further stall trips the fault.
    if (w_mem_state && !bus.MemReady) begin
      if (r_wait == WAIT_LIM) begin
        w_next      = S_HALT;
        w_wait_next = r_wait;
      end else begin
        w_wait_next = r_wait + WAIT_W'(1);
      end
    end
  end

  mc_ctrl_outdec u_outdec (
    .i_state     (r_state),
    .i_mem_ready (bus.MemReady),
    .i_zero      (bus.Zero),
    .i_rst       (Reset),
    .o_ctrl      (w_ctrl)
  );

  assign bus.MemRead   = w_ctrl.mem_read;
  assign bus.MemWrite  = w_ctrl.mem_write;
  assign bus.IorD      = w_ctrl.iord;
  assign bus.IRWrite   = w_ctrl.ir_write;
  assign bus.PCEn      = w_ctrl.pc_en;
  assign bus.RegDst    = w_ctrl.reg_dst;
  assign bus.MemtoReg  = w_ctrl.mem_to_reg;
  assign bus.RegWrite  = w_ctrl.reg_write;
  assign bus.ALUSrcA   = w_ctrl.alu_src_a;
  assign bus.ALUSrcB   = w_ctrl.alu_src_b;
  assign bus.ALUOp     = w_ctrl.alu_op;
  assign bus.PCSource  = w_ctrl.pc_source;
  assign bus.State     = r_state;
  assign bus.IllegalOp = w_illegal & ~Reset;
  assign bus.Fault     = r_fault & ~Reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
// Expected state/strobe vectors per cycle are queued with their stimulus.
module tb_multicycle_ctrl;

  logic Clock;
  logic Reset;
  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.master)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // {MemRead MemWrite IorD IRWrite PCEn RegDst MemtoReg RegWrite ALUSrcA ALUSrcB ALUOp PCSource IllegalOp Fault}
  logic [16:0] obs;
  assign obs = {bus.MemRead, bus.MemWrite, bus.IorD, bus.IRWrite, bus.PCEn, bus.RegDst,
                bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                bus.PCSource, bus.IllegalOp, bus.Fault};

  localparam logic [16:0] E_FRDY = 17'b1_0_0_1_1_0_0_0_0_01_00_00_0_0;
  localparam logic [16:0] E_FWT  = 17'b1_0_0_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [16:0] E_DEC  = 17'b0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [16:0] E_ILL  = 17'b0_0_0_0_0_0_0_0_0_11_00_00_1_0;
  localparam logic [16:0] E_MADR = 17'b0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [16:0] E_MRD  = 17'b1_0_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [16:0] E_MWB  = 17'b0_0_0_0_0_0_1_1_0_00_00_00_0_0;
  localparam logic [16:0] E_MWR  = 17'b0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [16:0] E_REX  = 17'b0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [16:0] E_RWB  = 17'b0_0_0_0_0_1_0_1_0_00_00_00_0_0;
  localparam logic [16:0] E_BQZ  = 17'b0_0_0_0_1_0_0_0_1_00_01_01_0_0;
  localparam logic [16:0] E_BQN  = 17'b0_0_0_0_0_0_0_0_1_00_01_01_0_0;
  localparam logic [16:0] E_J    = 17'b0_0_0_0_1_0_0_0_0_00_00_10_0_0;
  localparam logic [16:0] E_AEX  = 17'b0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [16:0] E_AWB  = 17'b0_0_0_0_0_0_0_1_0_00_00_00_0_0;
  localparam logic [16:0] E_HALT = 17'b0_0_0_0_0_0_0_0_0_00_00_00_0_1;
  localparam logic [16:0] E_NONE = 17'b0;

  typedef struct packed {
    logic [5:0]  op;
    logic        mr;
    logic        z;
    logic [3:0]  st;
    logic [16:0] o;
  } ent_t;

  ent_t sb[$];
  ent_t e;
  int   checks = 0;
  int   errors = 0;

  function automatic void push(logic [5:0] op, logic mr, logic z, logic [3:0] st, logic [16:0] o);
    ent_t n;
    n.op = op; n.mr = mr; n.z = z; n.st = st; n.o = o;
    sb.push_back(n);
  endfunction

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    bus.MemReady = 1'b0;
    #1;
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge Clock);
    bus.MemReady = 1'b1;
    Reset = 1'b1;
    #1;
    checks++;
    if (bus.State !== 4'd0) begin
      errors++;
      $display("FAIL reset_state got %0d want 0", bus.State);
    end
    checks++;
    if (obs !== E_NONE) begin
      errors++;
      $display("FAIL reset_outputs got %h want %h", obs, E_NONE);
    end
    Reset = 1'b0;
  endtask

  task automatic test_rtype();
    int cyc = 0;
    do_reset();
    push(6'b000000, 1, 0, 4'd0, E_FRDY);
    push(6'b000000, 1, 0, 4'd1, E_DEC);
    push(6'b000000, 1, 0, 4'd6, E_REX);
    push(6'b000000, 1, 0, 4'd7, E_RWB);
    push(6'b000000, 1, 0, 4'd0, E_FRDY);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.Op = e.op; bus.MemReady = e.mr; bus.Zero = e.z;
      #1;
      checks++;
      if ({bus.State, obs} !== {e.st, e.o}) begin
        errors++;
        $display("FAIL rtype cyc %0d state %0d want %0d outs %h want %h", cyc, bus.State, e.st, obs, e.o);
      end
      cyc++;
      @(negedge Clock);
    end
  endtask

  task automatic test_lw_wait();
    int cyc = 0;
    do_reset();
    push(6'b100011, 1, 0, 4'd0, E_FRDY);
    push(6'b100011, 1, 0, 4'd1, E_DEC);
    push(6'b100011, 1, 0, 4'd2, E_MADR);
    push(6'b100011, 0, 0, 4'd3, E_MRD);
    push(6'b100011, 0, 0, 4'd3, E_MRD);
    push(6'b100011, 0, 0, 4'd3, E_MRD);
    push(6'b100011, 1, 0, 4'd3, E_MRD);
    push(6'b100011, 1, 0, 4'd4, E_MWB);
    push(6'b100011, 1, 0, 4'd0, E_FRDY);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.Op = e.op; bus.MemReady = e.mr; bus.Zero = e.z;
      #1;
      checks++;
      if ({bus.State, obs} !== {e.st, e.o}) begin
        errors++;
        $display("FAIL lw_wait cyc %0d state %0d want %0d outs %h want %h", cyc, bus.State, e.st, obs, e.o);
      end
      cyc++;
      @(negedge Clock);
    end
  endtask

  task automatic test_beq();
    int cyc = 0;
    do_reset();
    push(6'b000100, 1, 1, 4'd0, E_FRDY);
    push(6'b000100, 1, 1, 4'd1, E_DEC);
    push(6'b000100, 1, 1, 4'd8, E_BQZ);
    push(6'b000100, 1, 0, 4'd0, E_FRDY);
    push(6'b000100, 1, 0, 4'd1, E_DEC);
    push(6'b000100, 1, 0, 4'd8, E_BQN);
    push(6'b000100, 1, 0, 4'd0, E_FRDY);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.Op = e.op; bus.MemReady = e.mr; bus.Zero = e.z;
      #1;
      checks++;
      if ({bus.State, obs} !== {e.st, e.o}) begin
        errors++;
        $display("FAIL beq cyc %0d state %0d want %0d outs %h want %h", cyc, bus.State, e.st, obs, e.o);
      end
      cyc++;
      @(negedge Clock);
    end
  endtask

  task automatic test_illegal();
    int cyc = 0;
    do_reset();
    push(6'b111111, 1, 0, 4'd0, E_FRDY);
    push(6'b111111, 1, 0, 4'd1, E_ILL);
    push(6'b111111, 1, 0, 4'd0, E_FRDY);
    push(6'b001000, 1, 0, 4'd1, E_DEC);
`ifdef MULTICYCLE_CTRL_ADDI_EN
    sb[3].o = E_DEC;
    push(6'b001000, 1, 0, 4'd10, E_AEX);
    push(6'b001000, 1, 0, 4'd11, E_AWB);
`else
    sb[3].o = E_ILL;
`endif
    push(6'b001000, 1, 0, 4'd0, E_FRDY);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.Op = e.op; bus.MemReady = e.mr; bus.Zero = e.z;
      #1;
      checks++;
      if ({bus.State, obs} !== {e.st, e.o}) begin
        errors++;
        $display("FAIL illegal cyc %0d state %0d want %0d outs %h want %h", cyc, bus.State, e.st, obs, e.o);
      end
      cyc++;
      @(negedge Clock);
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    do_reset();
    push(6'b000000, 1, 0, 4'd0, E_FRDY);
    push(6'b000000, 1, 0, 4'd1, E_DEC);
    push(6'b000000, 1, 0, 4'd6, E_REX);
    push(6'b000000, 1, 0, 4'd7, E_RWB);
    push(6'b000010, 1, 0, 4'd0, E_FRDY);
    push(6'b000010, 1, 0, 4'd1, E_DEC);
    push(6'b000010, 1, 0, 4'd9, E_J);
    push(6'b101011, 1, 0, 4'd0, E_FRDY);
    push(6'b101011, 1, 0, 4'd1, E_DEC);
    push(6'b101011, 1, 0, 4'd2, E_MADR);
    push(6'b101011, 1, 0, 4'd5, E_MWR);
    push(6'b101011, 1, 0, 4'd0, E_FRDY);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.Op = e.op; bus.MemReady = e.mr; bus.Zero = e.z;
      #1;
      checks++;
      if ({bus.State, obs} !== {e.st, e.o}) begin
        errors++;
        $display("FAIL b2b cyc %0d state %0d want %0d outs %h want %h", cyc, bus.State, e.st, obs, e.o);
      end
      cyc++;
      @(negedge Clock);
    end
  endtask

  task automatic test_wait_limit();
    int cyc = 0;
    do_reset();
    for (int i = 0; i < 15; i++) push(6'b000010, 0, 0, 4'd0, E_FWT);
    push(6'b000010, 1, 0, 4'd0, E_FRDY);
    push(6'b000010, 1, 0, 4'd1, E_DEC);
    push(6'b000010, 1, 0, 4'd9, E_J);
    push(6'b000010, 1, 0, 4'd0, E_FRDY);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.Op = e.op; bus.MemReady = e.mr; bus.Zero = e.z;
      #1;
      checks++;
      if ({bus.State, obs} !== {e.st, e.o}) begin
        errors++;
        $display("FAIL wait_limit cyc %0d state %0d want %0d outs %h want %h", cyc, bus.State, e.st, obs, e.o);
      end
      cyc++;
      @(negedge Clock);
    end
  endtask

  task automatic test_halt();
    int cyc = 0;
    do_reset();
    for (int i = 0; i < 16; i++) push(6'b000000, 0, 0, 4'd0, E_FWT);
    push(6'b000000, 0, 0, 4'd15, E_HALT);
    push(6'b000000, 1, 1, 4'd15, E_HALT);
    push(6'b000000, 1, 0, 4'd15, E_HALT);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.Op = e.op; bus.MemReady = e.mr; bus.Zero = e.z;
      #1;
      checks++;
      if ({bus.State, obs} !== {e.st, e.o}) begin
        errors++;
        $display("FAIL halt cyc %0d state %0d want %0d outs %h want %h", cyc, bus.State, e.st, obs, e.o);
      end
      cyc++;
      @(negedge Clock);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if ({bus.State, obs} !== {4'd0, E_NONE}) begin
      errors++;
      $display("FAIL halt_reset state %0d want 0 outs %h want %h", bus.State, obs, E_NONE);
    end
    Reset = 1'b0;
  endtask

  task automatic test_reset_mid_memwr();
    int cyc = 0;
    do_reset();
    push(6'b101011, 1, 0, 4'd0, E_FRDY);
    push(6'b101011, 1, 0, 4'd1, E_DEC);
    push(6'b101011, 1, 0, 4'd2, E_MADR);
    push(6'b101011, 0, 0, 4'd5, E_MWR);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.Op = e.op; bus.MemReady = e.mr; bus.Zero = e.z;
      #1;
      checks++;
      if ({bus.State, obs} !== {e.st, e.o}) begin
        errors++;
        $display("FAIL memwr cyc %0d state %0d want %0d outs %h want %h", cyc, bus.State, e.st, obs, e.o);
      end
      cyc++;
      @(negedge Clock);
    end
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if ({bus.State, obs} !== {4'd0, E_NONE}) begin
      errors++;
      $display("FAIL memwr_async_reset state %0d want 0 outs %h want %h", bus.State, obs, E_NONE);
    end
    Reset = 1'b0;
    @(negedge Clock);
    #1;
    checks++;
    if ({bus.State, obs} !== {4'd0, E_FWT}) begin
      errors++;
      $display("FAIL memwr_after_release state %0d want 0 outs %h want %h", bus.State, obs, E_FWT);
    end
  endtask

  initial begin
    Reset = 1'b1;
    bus.Op = 6'b0;
    bus.Zero = 1'b0;
    bus.MemReady = 1'b0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_back_to_back();
    test_wait_limit();
    test_halt();
    test_reset_mid_memwr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
